imem_arbiter: RTL and testbench
===============================

// Module: imem_arbiter
// PURPOSE
//  Shares the single instruction-memory port between two requesters:
//  - the core fetch unit (read-only);
//  - the program loader/debug port (read/write).
//  Sits between those requesters and a synchronous-read IMEM word array.
//  Per-cycle req/gnt arbitration, 1-cycle read latency, response routing,
//  alignment/range error checking, and fetch flush on redirect.
// PARAMETERS
//  IMSIZE   1024   IMEM depth in 32-bit words
//  AW       $clog2(IMSIZE)   word-address width driven to memory (derived)
// PORTS
//  clk        in   1    system clock; all state updates on posedge
//  rst        in   1    synchronous, active-high reset
//  f_req      in   1    fetch read request; f_addr held stable until f_gnt
//  f_addr     in   32   fetch byte address
//  f_flush    in   1    squash any in-flight fetch response
//  f_gnt      out  1    fetch request accepted this cycle
//  f_rvalid   out  1    fetch response valid (one cycle after f_gnt)
//  f_rdata    out  32   fetch instruction word
//  f_err      out  1    fetch response is an error (misaligned/out of range)
//  l_req      in   1    loader request
//  l_we       in   1    loader write (1) / read (0)
//  l_addr     in   32   loader byte address
//  l_wdata    in   32   loader write data
//  l_lock     in   1    while high, fetch is never granted
//  l_gnt      out  1    loader request accepted this cycle
//  l_rvalid   out  1    loader response/ack valid (one cycle after l_gnt)
//  l_rdata    out  32   loader read data (0 for writes)
//  l_err      out  1    loader response is an error
//  m_en       out  1    memory access enable
//  m_we       out  1    memory write enable
//  m_addr     out  AW   memory word index = addr[AW+1:2]
//  m_wdata    out  32   memory write data
//  m_rdata    in   32   memory read data, valid the cycle after m_en
// BEHAVIOUR
//  Reset:
//  - All *_rvalid, *_err, m_en, m_we = 0; rdata outputs = 0.
//  - Round-robin pointer = loader-last, so fetch wins the first tie.
//  - In-flight response is discarded.
//  Arbitration (combinational from registered state):
//  - Grant only when req=1; at most one grant per cycle.
//  - Both requesting, l_lock=0: grant the port NOT granted last.
//  - l_lock=1: f_gnt=0; loader granted whenever l_req=1.
//  - Pointer updates only on a grant.
//  - A requester keeps req/addr/wdata stable until gnt; back-to-back grants
//    are allowed every cycle (fully pipelined).
//  Access:
//  - On grant, address check. Error if addr[1:0]!=0 or addr[31:2]>=IMSIZE.
//  - No error: m_en=1, m_we=l_we&l_gnt, m_addr/m_wdata driven same cycle.
//  - Error: m_en=0, and no write occurs.
//  - Fetch never writes.
//  Response (registered, latency exactly 1 cycle after gnt):
//  - An owner/err/we register captures the grant.
//  - Next cycle, the owner's rvalid=1.
//  - rdata = m_rdata, or 0 on error or write.
//  - err = registered error flag.
//  - The non-owner's rvalid=0.
//  Flush:
//  - f_flush=1 in the grant cycle: the fetch response is marked dead.
//  - f_flush=1 in the response cycle: the fetch response is also dead.
//  - Dead response: f_rvalid stays 0.
//  - Flush and f_gnt in the same cycle: that grant is squashed.
//  - Flush never affects loader responses.
//  Reset mid-operation: a pending response is dropped and no rvalid follows.
// TESTING
//  1. Reset, f_req=1, f_addr=0x8, mem[2]=0x00500093
//     -> f_gnt same cycle; next cycle f_rvalid=1, f_rdata=0x00500093, f_err=0.
//  2. f_req=l_req=1 held 4 cycles, l_lock=0
//     -> grants alternate F,L,F,L; each rvalid lands 1 cycle after its gnt.
//  3. l_lock=1, l_we=1, l_addr=0x10, l_wdata=0xDEADBEEF, then fetch 0x10
//     -> f_gnt=0 while locked, l_rvalid ack with l_rdata=0;
//        after unlock, fetch returns 0xDEADBEEF.
//  4. f_addr=0x6, then f_addr=IMSIZE*4
//     -> both granted, m_en=0, f_rvalid=1 with f_err=1, f_rdata=0.
//  5. f_gnt at cycle N, f_flush=1 at cycle N+1 -> no f_rvalid at N+1;
//     a loader read granted at N+1 still returns l_rvalid at N+2.
//  6. rst=1 in the cycle after a loader read grant
//     -> l_rvalid stays 0; next tie after reset is granted to fetch.

Source files
------------

// File: rtl/imem_arbiter_if.sv
// Bundle of the fetch, loader and IMEM-side signals of the instruction-memory arbiter.
// The slave modport is the arbiter's view; master is the requester/memory view.
interface imem_arbiter_if #(
  parameter int IMSIZE = 1024,
  parameter int AW     = $clog2(IMSIZE)
);
  logic          f_req;
  logic [31:0]   f_addr;
  logic          f_flush;
  logic          f_gnt;
  logic          f_rvalid;
  logic [31:0]   f_rdata;
  logic          f_err;

  logic          l_req;
  logic          l_we;
  logic [31:0]   l_addr;
  logic [31:0]   l_wdata;
  logic          l_lock;
  logic          l_gnt;
  logic          l_rvalid;
  logic [31:0]   l_rdata;
  logic          l_err;

  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;

  modport slave (
    input  f_req, f_addr, f_flush,
    input  l_req, l_we, l_addr, l_wdata, l_lock,
    input  m_rdata,
    output f_gnt, f_rvalid, f_rdata, f_err,
    output l_gnt, l_rvalid, l_rdata, l_err,
    output m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output f_req, f_addr, f_flush,
    output l_req, l_we, l_addr, l_wdata, l_lock,
    output m_rdata,
    input  f_gnt, f_rvalid, f_rdata, f_err,
    input  l_gnt, l_rvalid, l_rdata, l_err,
    input  m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// Shares one synchronous-read IMEM port between the fetch unit and the loader:
// round-robin req/gnt, address checking, 1-cycle response routing and fetch flush.
module imem_arbiter #(
  parameter int IMSIZE = 1024
) (
  input  logic          clk,
  input  logic          rst,
  imem_arbiter_if.slave bus
);
  localparam int AW = $clog2(IMSIZE);

  logic        last_l_q, last_l_d;
  logic        f_pend_q, f_pend_d;
  logic        l_pend_q, l_pend_d;
  logic        err_q, err_d;
  logic        we_q, we_d;

  logic        f_gnt, l_gnt;
  logic        addr_err;
  logic [31:0] sel_addr;
  logic        f_rvalid, l_rvalid;

  // Ties go to whichever port was not granted last; lock shuts fetch out entirely.
  assign f_gnt = !rst && bus.f_req && !bus.l_lock && (!bus.l_req || last_l_q);
  assign l_gnt = !rst && bus.l_req && (bus.l_lock || !bus.f_req || !last_l_q);

  assign sel_addr = l_gnt ? bus.l_addr : bus.f_addr;
  assign addr_err = (sel_addr[1:0] != 2'b00) || (sel_addr[31:2] >= 30'(IMSIZE));

  assign bus.f_gnt   = f_gnt;
  assign bus.l_gnt   = l_gnt;
  assign bus.m_en    = (f_gnt || l_gnt) && !addr_err;
  assign bus.m_we    = l_gnt && bus.l_we && !addr_err;
  assign bus.m_addr  = sel_addr[AW+1:2];
  assign bus.m_wdata = bus.l_wdata;

  always_comb begin
    last_l_d = last_l_q;
    if (f_gnt || l_gnt) last_l_d = l_gnt;
    f_pend_d = f_gnt && !bus.f_flush;
    l_pend_d = l_gnt;
    err_d    = addr_err;
    we_d     = l_gnt && bus.l_we;
  end

  // grant -> response stage boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      last_l_q <= 1'b1;
      f_pend_q <= 1'b0;
      l_pend_q <= 1'b0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      last_l_q <= last_l_d;
      f_pend_q <= f_pend_d;
      l_pend_q <= l_pend_d;
      err_q    <= err_d;
      we_q     <= we_d;
    end
  end

  // A flush in the response cycle still kills the fetch response.
  assign f_rvalid     = f_pend_q && !bus.f_flush && !rst;
  assign l_rvalid     = l_pend_q && !rst;
  assign bus.f_rvalid = f_rvalid;
  assign bus.l_rvalid = l_rvalid;
  assign bus.f_err    = f_rvalid && err_q;
  assign bus.l_err    = l_rvalid && err_q;
  assign bus.f_rdata  = (f_rvalid && !err_q) ? bus.m_rdata : 32'h0;
  assign bus.l_rdata  = (l_rvalid && !err_q && !we_q) ? bus.m_rdata : 32'h0;
endmodule

// File: tb/tb_imem_arbiter.sv
// Directed plus random bench for imem_arbiter with a behavioural IMEM and reference model.
module tb_imem_arbiter;
  localparam int IMSIZE = 1024;
  localparam int AW     = $clog2(IMSIZE);

  logic clk;
  logic rst;
  logic tb_init;
  int   n_assert = 0;
  int   n_fail   = 0;

  imem_arbiter_if #(.IMSIZE(IMSIZE)) bus ();
  imem_arbiter #(.IMSIZE(IMSIZE)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    return (i == 2) ? 32'h00500093 : ((32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000);
  endfunction

  // Memory stub: unwritten words read as init_word, one cycle read latency.
  logic [31:0]     mem [IMSIZE];
  logic [IMSIZE-1:0] wr;
  logic [31:0]     m_rdata_r;
  assign bus.m_rdata = m_rdata_r;
  always @(posedge clk) begin
    if (tb_init) wr <= '0;
    else if (bus.m_en) begin
      if (bus.m_we) begin
        mem[bus.m_addr] <= bus.m_wdata;
        wr[bus.m_addr]  <= 1'b1;
      end
      m_rdata_r <= wr[bus.m_addr] ? mem[bus.m_addr] : init_word(int'(bus.m_addr));
    end
  end

  // Reference model state
  logic [31:0] refmem [IMSIZE];
  bit          last_l;
  bit          pf, pl, perr;
  logic [31:0] pdata;
  bit          gf, gl, bad;
  int unsigned widx;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    logic [31:0] a;
    bit fv, lv;
    #1;
    gf = 0; gl = 0;
    if (!rst) begin
      if (bus.l_lock) gl = bus.l_req;
      else if (bus.f_req && bus.l_req) begin
        gf = last_l;
        gl = !last_l;
      end else begin
        gf = bus.f_req;
        gl = bus.l_req;
      end
    end
    a    = gl ? bus.l_addr : bus.f_addr;
    bad  = (a % 4 != 0) || (a / 4 >= IMSIZE);
    widx = bad ? 0 : a / 4;
    fv   = !rst && pf && !bus.f_flush;
    lv   = !rst && pl;
    chk("f_gnt", 32'(bus.f_gnt), 32'(gf));
    chk("l_gnt", 32'(bus.l_gnt), 32'(gl));
    chk("m_en", 32'(bus.m_en), 32'((gf || gl) && !bad));
    chk("m_we", 32'(bus.m_we), 32'(gl && bus.l_we && !bad));
    if ((gf || gl) && !bad) chk("m_addr", 32'(bus.m_addr), widx);
    if (gl && bus.l_we && !bad) chk("m_wdata", bus.m_wdata, bus.l_wdata);
    chk("f_rvalid", 32'(bus.f_rvalid), 32'(fv));
    chk("f_rdata", bus.f_rdata, fv ? pdata : 32'h0);
    chk("f_err", 32'(bus.f_err), 32'(fv && perr));
    chk("l_rvalid", 32'(bus.l_rvalid), 32'(lv));
    chk("l_rdata", bus.l_rdata, lv ? pdata : 32'h0);
    chk("l_err", 32'(bus.l_err), 32'(lv && perr));
  endtask

  task automatic tick();
    if (rst) begin
      pf = 0; pl = 0; last_l = 1;
    end else begin
      pf    = gf && !bus.f_flush;
      pl    = gl;
      perr  = bad;
      pdata = (bad || (gl && bus.l_we)) ? 32'h0 : refmem[widx];
      if (gl && bus.l_we && !bad) refmem[widx] = bus.l_wdata;
      if (gf || gl) last_l = gl;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.f_req = 0; bus.f_addr = 0; bus.f_flush = 0;
    bus.l_req = 0; bus.l_we = 0; bus.l_addr = 0; bus.l_wdata = 0; bus.l_lock = 0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst = 1; settle(); tick(); rst = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    int r;
    r = $urandom_range(0, 15);
    a = 32'($urandom_range(0, 63)) << 2;
    if (r == 0) a = 32'($urandom_range(IMSIZE, IMSIZE + 100)) << 2;
    if (r == 1) a = a | 32'($urandom_range(1, 3));
    return a;
  endfunction

  initial begin
    for (int i = 0; i < IMSIZE; i++) refmem[i] = init_word(i);
    pdata = 0; perr = 0; pf = 0; pl = 0; last_l = 1;
    idle_inputs();
    rst = 1; tb_init = 1;
    @(posedge clk); #1;
    tb_init = 0;
    settle(); tick();
    rst = 0;

    // 1: plain fetch read after reset
    bus.f_req = 1; bus.f_addr = 32'h8;
    settle(); chk("t1_f_gnt", 32'(bus.f_gnt), 32'd1); tick();
    bus.f_req = 0;
    settle();
    chk("t1_f_rvalid", 32'(bus.f_rvalid), 32'd1);
    chk("t1_f_rdata", bus.f_rdata, 32'h00500093);
    chk("t1_f_err", 32'(bus.f_err), 32'd0);
    tick();

    // 2: round-robin alternation starting with fetch
    reset_dut();
    bus.f_req = 1; bus.f_addr = 32'h40;
    bus.l_req = 1; bus.l_we = 0; bus.l_addr = 32'h44;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("t2_f_gnt", 32'(bus.f_gnt), 32'(k % 2 == 0));
      chk("t2_l_gnt", 32'(bus.l_gnt), 32'(k % 2 == 1));
      if (k > 0) chk("t2_f_rvalid", 32'(bus.f_rvalid), 32'(k % 2 == 1));
      tick();
    end
    idle_inputs(); settle(); tick();

    // 3: locked loader write, then fetch of the written word
    bus.l_lock = 1; bus.l_req = 1; bus.l_we = 1; bus.l_addr = 32'h10; bus.l_wdata = 32'hDEADBEEF;
    bus.f_req = 1; bus.f_addr = 32'h10;
    settle();
    chk("t3_f_gnt", 32'(bus.f_gnt), 32'd0);
    chk("t3_l_gnt", 32'(bus.l_gnt), 32'd1);
    tick();
    bus.l_req = 0; bus.l_we = 0;
    settle();
    chk("t3_l_rvalid", 32'(bus.l_rvalid), 32'd1);
    chk("t3_l_rdata", bus.l_rdata, 32'h0);
    chk("t3_f_gnt_lock", 32'(bus.f_gnt), 32'd0);
    tick();
    bus.l_lock = 0;
    settle(); chk("t3_f_gnt_unlock", 32'(bus.f_gnt), 32'd1); tick();
    bus.f_req = 0;
    settle(); chk("t3_f_rdata", bus.f_rdata, 32'hDEADBEEF); tick();

    // 4: misaligned then out-of-range fetch
    bus.f_req = 1; bus.f_addr = 32'h6;
    settle();
    chk("t4_gnt_mis", 32'(bus.f_gnt), 32'd1);
    chk("t4_men_mis", 32'(bus.m_en), 32'd0);
    tick();
    bus.f_addr = 32'(IMSIZE * 4);
    settle();
    chk("t4_err_mis", 32'(bus.f_err), 32'd1);
    chk("t4_rdata_mis", bus.f_rdata, 32'h0);
    chk("t4_men_oor", 32'(bus.m_en), 32'd0);
    tick();
    bus.f_req = 0;
    settle();
    chk("t4_rvalid_oor", 32'(bus.f_rvalid), 32'd1);
    chk("t4_err_oor", 32'(bus.f_err), 32'd1);
    tick();

    // 5: flush in response cycle and in grant cycle
    bus.f_req = 1; bus.f_addr = 32'h20;
    settle(); tick();
    bus.f_req = 0; bus.f_flush = 1; bus.l_req = 1; bus.l_addr = 32'h24;
    settle();
    chk("t5_f_rvalid_flush", 32'(bus.f_rvalid), 32'd0);
    chk("t5_l_gnt", 32'(bus.l_gnt), 32'd1);
    tick();
    bus.f_flush = 0; bus.l_req = 0;
    settle(); chk("t5_l_rvalid", 32'(bus.l_rvalid), 32'd1); tick();
    bus.f_req = 1; bus.f_flush = 1; bus.f_addr = 32'h28;
    settle(); tick();
    bus.f_req = 0; bus.f_flush = 0;
    settle(); chk("t5_f_rvalid_gflush", 32'(bus.f_rvalid), 32'd0); tick();

    // 6: reset drops pending responses and restores fetch priority
    bus.f_req = 1; bus.f_addr = 32'h30;
    settle(); tick();
    idle_inputs(); rst = 1;
    settle(); chk("t6_f_rvalid_rst", 32'(bus.f_rvalid), 32'd0); tick();
    rst = 0;
    bus.l_req = 1; bus.l_addr = 32'h34;
    settle(); tick();
    idle_inputs(); rst = 1;
    settle(); chk("t6_l_rvalid_rst", 32'(bus.l_rvalid), 32'd0); tick();
    rst = 0;
    bus.f_req = 1; bus.f_addr = 32'h38; bus.l_req = 1; bus.l_addr = 32'h3C;
    settle(); chk("t6_tie_fetch", 32'(bus.f_gnt), 32'd1); tick();
    idle_inputs(); settle(); tick();

    // Random traffic; a waiting requester holds its request until granted.
    for (int i = 0; i < 600; i++) begin
      if (!(bus.f_req && !gf)) begin
        bus.f_req  = ($urandom_range(0, 3) != 0);
        bus.f_addr = rand_addr();
      end
      if (!(bus.l_req && !gl)) begin
        bus.l_req   = ($urandom_range(0, 2) != 0);
        bus.l_we    = ($urandom_range(0, 2) == 0);
        bus.l_addr  = rand_addr();
        bus.l_wdata = $urandom;
      end
      bus.f_flush = ($urandom_range(0, 7) == 0);
      bus.l_lock  = ($urandom_range(0, 7) == 0);
      rst         = ($urandom_range(0, 99) == 0);
      settle();
      tick();
    end
    rst = 0; idle_inputs(); settle(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
